// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage Tnew tracking, D-stage stall/forward selects, mult/div busy window.
// Latency: stall and forward selects are combinational (0 cycles); stage records update 1 cycle after D presents an instruction.
// Backpressure: stall freezes PC and F/D and injects one bubble into E per stalled cycle; M and W always advance.
//
// Ports:
//   clk, reset                     rising-edge clock, asynchronous active-high reset
//   d_valid                        D holds a real instruction (0 = bubble)
//   d_rs, d_rt                     D source registers
//   d_tuse_rs, d_tuse_rt           cycles from D until each operand is consumed
//   d_dst, d_tnew                  D destination register and its Tnew as seen in E
//   d_md_op, d_md_use              mult/div start (01 mult, 10 div) and HI/LO-or-md usage
//   stall                          freeze request
//   fwd_rs_sel, fwd_rt_sel         D operand source: 0 regfile, 1 E, 2 M, 3 W
//   rege/regm/regw, tnew_e/m/w     stage destination registers and remaining Tnew
//   md_busy                        mult/div unit busy
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [3:0] d_tnew,
    input  logic [1:0] d_md_op,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic [4:0] rege,
    output logic [4:0] regm,
    output logic [4:0] regw,
    output logic [3:0] tnew_e,
    output logic [3:0] tnew_m,
    output logic [3:0] tnew_w,
    output logic       md_busy
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    logic [3:0] md_cnt;
    logic       data_stall;
    logic       md_stall;
    logic       md_load;

    function automatic logic [3:0] sat_dec(input logic [3:0] t);
        return (t == 4'd0) ? 4'd0 : t - 4'd1;
    endfunction

    // A source hazards when any stage writing it still needs more cycles
    // than the D instruction can wait before consuming the operand.
    function automatic logic src_hazard(
        input logic [4:0] s,
        input logic [1:0] tuse,
        input logic [4:0] re, input logic [3:0] te,
        input logic [4:0] rm, input logic [3:0] tm,
        input logic [4:0] rw, input logic [3:0] tw
    );
        logic [3:0] tu;
        tu = {2'b00, tuse};
        if (s == 5'd0) begin
            return 1'b0;
        end
        return ((s == re) && (te > tu)) ||
               ((s == rm) && (tm > tu)) ||
               ((s == rw) && (tw > tu));
    endfunction

    // The youngest stage holding s decides: ready result forwards from it,
    // a not-yet-ready one blocks older stages (the stall covers that case).
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] s,
        input logic [4:0] re, input logic [3:0] te,
        input logic [4:0] rm, input logic [3:0] tm,
        input logic [4:0] rw, input logic [3:0] tw
    );
        if (s == 5'd0) begin
            return 2'd0;
        end
        if (s == re) begin
            return (te == 4'd0) ? 2'd1 : 2'd0;
        end
        if (s == rm) begin
            return (tm == 4'd0) ? 2'd2 : 2'd0;
        end
        if (s == rw) begin
            return (tw == 4'd0) ? 2'd3 : 2'd0;
        end
        return 2'd0;
    endfunction

    assign md_busy = (md_cnt != 4'd0);

    always_comb begin
        data_stall = 1'b0;
        md_stall   = 1'b0;
        if (d_valid) begin
            data_stall = src_hazard(d_rs, d_tuse_rs, rege, tnew_e, regm, tnew_m, regw, tnew_w) ||
                         src_hazard(d_rt, d_tuse_rt, rege, tnew_e, regm, tnew_m, regw, tnew_w);
            md_stall   = d_md_use && md_busy;
        end
    end

    assign stall = data_stall || md_stall;

    always_comb begin
        fwd_rs_sel = fwd_sel(d_rs, rege, tnew_e, regm, tnew_m, regw, tnew_w);
        fwd_rt_sel = fwd_sel(d_rt, rege, tnew_e, regm, tnew_m, regw, tnew_w);
    end

    // Only an instruction actually leaving D starts the mult/div window;
    // the reserved op code behaves as no operation.
    assign md_load = d_valid && !stall && ((d_md_op == 2'b01) || (d_md_op == 2'b10));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rege   <= 5'd0;
            tnew_e <= 4'd0;
            regm   <= 5'd0;
            tnew_m <= 4'd0;
            regw   <= 5'd0;
            tnew_w <= 4'd0;
        end else begin
            if (stall || !d_valid) begin
                rege   <= 5'd0;
                tnew_e <= 4'd0;
            end else begin
                rege   <= d_dst;
                tnew_e <= d_tnew;
            end
            regm   <= rege;
            tnew_m <= sat_dec(tnew_e);
            regw   <= regm;
            tnew_w <= sat_dec(tnew_m);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (md_load) begin
            md_cnt <= (d_md_op == 2'b01) ? MULT_LOAD : DIV_LOAD;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_md_op;
    logic [3:0] d_tnew;
    logic       d_md_use;
    logic       stall;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic [4:0] rege, regm, regw;
    logic [3:0] tnew_e, tnew_m, tnew_w;
    logic       md_busy;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_md_op(d_md_op), .d_md_use(d_md_use),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .rege(rege), .regm(regm), .regw(regw),
        .tnew_e(tnew_e), .tnew_m(tnew_m), .tnew_w(tnew_w), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: history of what entered E over the last three edges,
    // with each entry's original Tnew; a stage's remaining Tnew is its age-
    // adjusted value. md window is tracked as the last busy cycle number.
    int h_reg[3];
    int h_tnew[3];
    int cyc;
    int md_until;
    int exp_stall;

    function automatic int stage_t(int k);
        int t;
        t = h_tnew[k] - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int m_busy();
        return (cyc <= md_until) ? 1 : 0;
    endfunction

    function automatic int m_sel(int s);
        if (s == 0) return 0;
        for (int k = 0; k < 3; k++) begin
            if (h_reg[k] == s) return (stage_t(k) == 0) ? k + 1 : 0;
        end
        return 0;
    endfunction

    function automatic int m_hazard(int s, int tuse);
        if (s == 0) return 0;
        for (int k = 0; k < 3; k++) begin
            if (h_reg[k] == s && stage_t(k) > tuse) return 1;
        end
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            h_reg[k]  = 0;
            h_tnew[k] = 0;
        end
        md_until = -1;
    endtask

    task automatic check_all(input string tag);
        int st;
        st = 0;
        if (d_valid) begin
            if (m_hazard(int'(d_rs), int'(d_tuse_rs)) != 0) st = 1;
            if (m_hazard(int'(d_rt), int'(d_tuse_rt)) != 0) st = 1;
            if (d_md_use && m_busy() != 0) st = 1;
        end
        exp_stall = st;
        chk({tag, ".stall"},  int'(stall),      st);
        chk({tag, ".fwd_rs"}, int'(fwd_rs_sel), m_sel(int'(d_rs)));
        chk({tag, ".fwd_rt"}, int'(fwd_rt_sel), m_sel(int'(d_rt)));
        chk({tag, ".rege"},   int'(rege),       h_reg[0]);
        chk({tag, ".regm"},   int'(regm),       h_reg[1]);
        chk({tag, ".regw"},   int'(regw),       h_reg[2]);
        chk({tag, ".tnew_e"}, int'(tnew_e),     stage_t(0));
        chk({tag, ".tnew_m"}, int'(tnew_m),     stage_t(1));
        chk({tag, ".tnew_w"}, int'(tnew_w),     stage_t(2));
        chk({tag, ".md_busy"}, int'(md_busy),   m_busy());
    endtask

    // Called just after a falling edge: apply D inputs, let them settle, compare.
    task automatic drive(input string tag, input int v, input int rs, input int rt,
                         input int tu_rs, input int tu_rt, input int dst, input int tn,
                         input int op, input int use_md);
        d_valid   = v[0];
        d_rs      = 5'(rs);
        d_rt      = 5'(rt);
        d_tuse_rs = 2'(tu_rs);
        d_tuse_rt = 2'(tu_rt);
        d_dst     = 5'(dst);
        d_tnew    = 4'(tn);
        d_md_op   = 2'(op);
        d_md_use  = use_md[0];
        #1;
        check_all(tag);
    endtask

    task automatic nop(input string tag);
        drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (d_valid && exp_stall == 0 && (d_md_op == 2'b01 || d_md_op == 2'b10))
                md_until = cyc + ((d_md_op == 2'b01) ? 5 : 10);
            h_reg[2]  = h_reg[1];
            h_tnew[2] = h_tnew[1];
            h_reg[1]  = h_reg[0];
            h_tnew[1] = h_tnew[0];
            if (d_valid && exp_stall == 0) begin
                h_reg[0]  = int'(d_dst);
                h_tnew[0] = int'(d_tnew);
            end else begin
                h_reg[0]  = 0;
                h_tnew[0] = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        nop("reset");
        chk("reset.stall_zero", int'(stall), 0);
        tick();
        reset = 1'b0;
    endtask

    int nstall, nbusy;

    initial begin
        reset = 1'b1;
        cyc = 0;
        exp_stall = 0;
        model_clear();
        d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0;
        d_dst = 0; d_tnew = 0; d_md_op = 0; d_md_use = 0;
        @(negedge clk);
        do_reset();

        // Load-use: lw $5 then addu rs=$5 tuse=1.
        drive("lu.lw", 1, 0, 0, 0, 0, 5, 2, 0, 0);
        tick();
        drive("lu.addu", 1, 5, 0, 1, 1, 6, 1, 0, 0);
        chk("lu.stall1", int'(stall), 1);
        tick();
        drive("lu.addu2", 1, 5, 0, 1, 1, 6, 1, 0, 0);
        chk("lu.stall0", int'(stall), 0);
        chk("lu.tnew_m", int'(tnew_m), 1);
        tick();
        nop("lu.after");
        chk("lu.regw", int'(regw), 5);
        chk("lu.tnew_w", int'(tnew_w), 0);
        tick();

        // Branch after ALU: addu $3 then beq rs=$3 tuse=0.
        do_reset();
        drive("br.addu", 1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        drive("br.beq", 1, 3, 0, 0, 0, 0, 0, 0, 0);
        chk("br.stall1", int'(stall), 1);
        tick();
        drive("br.beq2", 1, 3, 0, 0, 0, 0, 0, 0, 0);
        chk("br.stall0", int'(stall), 0);
        chk("br.fwd_m", int'(fwd_rs_sel), 2);
        chk("br.regm", int'(regm), 3);
        tick();

        // Priority: E and M both write $7 with Tnew 0.
        do_reset();
        drive("pr.i1", 1, 0, 0, 0, 0, 7, 0, 0, 0);
        tick();
        drive("pr.i2", 1, 0, 0, 0, 0, 7, 0, 0, 0);
        tick();
        drive("pr.use", 1, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("pr.fwd_e", int'(fwd_rs_sel), 1);
        drive("pr.r0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pr.r0_sel", int'(fwd_rs_sel), 0);
        chk("pr.r0_stall", int'(stall), 0);
        tick();

        // mult then mfhi.
        do_reset();
        drive("md.mult", 1, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        nstall = 0;
        nbusy  = 0;
        for (int i = 0; i < 20; i++) begin
            drive("md.mfhi", 1, 0, 0, 0, 0, 8, 1, 0, 1);
            if (md_busy) nbusy++;
            if (!stall) break;
            nstall++;
            tick();
        end
        chk("md.mult_stalls", nstall, 5);
        chk("md.mult_busy", nbusy, 5);
        tick();

        // div interrupted by reset in its third busy cycle.
        do_reset();
        drive("dv.div", 1, 0, 0, 0, 0, 0, 0, 2, 1);
        tick();
        nop("dv.c1");
        tick();
        nop("dv.c2");
        tick();
        nop("dv.c3");
        chk("dv.busy_pre", int'(md_busy), 1);
        reset = 1'b1;
        model_clear();
        nop("dv.rst");
        chk("dv.busy_rst", int'(md_busy), 0);
        tick();
        reset = 1'b0;
        drive("dv.next", 1, 4, 0, 0, 0, 2, 1, 0, 1);
        chk("dv.next_stall", int'(stall), 0);
        tick();

        // Bubble with a stray destination.
        do_reset();
        drive("bb.bubble", 0, 0, 0, 0, 0, 9, 3, 0, 0);
        tick();
        nop("bb.after");
        chk("bb.rege", int'(rege), 0);
        chk("bb.tnew_e", int'(tnew_e), 0);
        tick();

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                drive("rnd",
                      ($urandom_range(0, 9) != 0) ? 1 : 0,
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 7),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3),
                      ($urandom_range(0, 11) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 3) == 0) ? 1 : 0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
